// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states,
// compare result codes and the opcode class decoder.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_RSVD = 4'b1111;

    localparam logic [1:0] CMP_EQ_RES = 2'd1;
    localparam logic [1:0] CMP_GT_RES = 2'd2;
    localparam logic [1:0] CMP_LT_RES = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    typedef struct packed {
        logic arith;
        logic logic_c;
        logic cmp;
        logic shift;
    } class_t;

    // Map an opcode to its class flags; reserved opcode has no class.
    function automatic class_t class_decode(input logic [3:0] op);
        class_t c;
        c = 4'b0000;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV:                   c.arith   = 1'b1;
            OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR:  c.logic_c = 1'b1;
            OP_EQ, OP_GT, OP_LT:                              c.cmp     = 1'b1;
            OP_SHR, OP_SHL:                                   c.shift   = 1'b1;
            default:                                          c         = 4'b0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// done is raised once WIDTH iterations have completed and drops on the
// following edge.
module alu_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;
    logic             done_s;

    // Partial remainder shifted left with the next dividend bit; the
    // difference fits WIDTH bits because the remainder stays below divisor.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s[WIDTH-1:0] - dvs_r;
        ge_s      = (shifted_s >= {1'b0, dvs_r});
        done_s    = busy_r && (cnt_r == CW'(WIDTH));
    end

    // Load on start, iterate while busy, release after the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r <= 1'b1;
            cnt_r  <= {CW{1'b0}};
            quo_r  <= dividend;
            rem_r  <= {WIDTH{1'b0}};
            dvs_r  <= divisor;
        end else if (done_s) begin
            busy_r <= 1'b0;
        end else if (busy_r) begin
            cnt_r <= cnt_r + CW'(1);
            if (ge_s) begin
                rem_r <= diff_s;
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shifted_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done      = done_s;
    assign quotient  = quo_r;
    assign remainder = rem_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready input handshake. Single-cycle ops are
// registered at accept and produce results one edge later; division by a
// non-zero divisor runs through the iterative divider.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [WIDTH-1:0] ALU_OUT_HI,
    output logic             out_valid,
    output logic             ARITH_FLAG,
    output logic             LOGIC_FLAG,
    output logic             CMP_FLAG,
    output logic             SHIFT_FLAG,
    output logic             CARRY_FLAG,
    output logic             ZERO_FLAG,
    output logic             DIV_ZERO
);

    state_t           state_r, state_nxt_s;
    logic             in_ready_s;
    logic             accept_s, div_start_s;
    logic             pend_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;

    logic             div_done_s;
    logic [WIDTH-1:0] div_quo_s, div_rem_s;

    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] mul_s;
    logic [WIDTH-1:0]   res_lo_s, res_hi_s;
    logic               carry_s, divz_s;
    class_t             cls_s, div_cls_s;

    logic [WIDTH-1:0] out_lo_r, out_hi_r;
    logic             out_valid_r, carry_r, zero_r, divz_r;
    class_t           cls_r;

    assign accept_s    = in_valid && in_ready_s;
    assign div_start_s = accept_s && (ALU_FUN == OP_DIV) && (B != {WIDTH{1'b0}});
    assign div_cls_s   = class_decode(OP_DIV);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: enter DIV on a real division, leave when it completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (div_start_s) state_nxt_s = DIV;
                else             state_nxt_s = IDLE;
            end
            DIV: begin
                if (div_done_s) state_nxt_s = IDLE;
                else            state_nxt_s = DIV;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output: ready only while idle.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DIV:     in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
        endcase
    end

    // Capture operands at accept; pend_r marks a single-cycle op to retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
            op_r   <= 4'b0000;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
        end else begin
            pend_r <= accept_s && !div_start_s;
            if (accept_s) begin
                op_r <= ALU_FUN;
                a_r  <= A;
                b_r  <= B;
            end
        end
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start_s),
        .dividend  (A),
        .divisor   (B),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Single-cycle datapath on the captured operands. OP_DIV only reaches
    // here with a zero divisor.
    always_comb begin
        sum_s    = {1'b0, a_r} + {1'b0, b_r};
        mul_s    = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        res_lo_s = {WIDTH{1'b0}};
        res_hi_s = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        divz_s   = 1'b0;
        cls_s    = class_decode(op_r);
        case (op_r)
            OP_ADD:  begin res_lo_s = sum_s[WIDTH-1:0]; carry_s = sum_s[WIDTH]; end
            OP_SUB:  begin res_lo_s = a_r - b_r; carry_s = (a_r < b_r); end
            OP_MUL:  begin res_lo_s = mul_s[WIDTH-1:0]; res_hi_s = mul_s[2*WIDTH-1:WIDTH]; end
            OP_DIV:  begin res_lo_s = {WIDTH{1'b1}}; res_hi_s = a_r; divz_s = 1'b1; end
            OP_AND:  res_lo_s = a_r & b_r;
            OP_OR:   res_lo_s = a_r | b_r;
            OP_NAND: res_lo_s = ~(a_r & b_r);
            OP_NOR:  res_lo_s = ~(a_r | b_r);
            OP_XOR:  res_lo_s = a_r ^ b_r;
            OP_XNOR: res_lo_s = ~(a_r ^ b_r);
            OP_EQ: begin
                if (a_r == b_r) res_lo_s = {{(WIDTH-2){1'b0}}, CMP_EQ_RES};
                else            res_lo_s = {WIDTH{1'b0}};
            end
            OP_GT: begin
                if (a_r > b_r) res_lo_s = {{(WIDTH-2){1'b0}}, CMP_GT_RES};
                else           res_lo_s = {WIDTH{1'b0}};
            end
            OP_LT: begin
                if (a_r < b_r) res_lo_s = {{(WIDTH-2){1'b0}}, CMP_LT_RES};
                else           res_lo_s = {WIDTH{1'b0}};
            end
            OP_SHR:  begin res_lo_s = {1'b0, a_r[WIDTH-1:1]}; carry_s = a_r[0]; end
            OP_SHL:  begin res_lo_s = {a_r[WIDTH-2:0], 1'b0}; carry_s = a_r[WIDTH-1]; end
            default: begin res_lo_s = {WIDTH{1'b0}}; cls_s = 4'b0000; end
        endcase
    end

    // Result/flag registers: load on retire, otherwise hold; out_valid pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_lo_r    <= {WIDTH{1'b0}};
            out_hi_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            divz_r      <= 1'b0;
            cls_r       <= 4'b0000;
        end else if (pend_r) begin
            out_valid_r <= 1'b1;
            out_lo_r    <= res_lo_s;
            out_hi_r    <= res_hi_s;
            carry_r     <= carry_s;
            zero_r      <= (res_lo_s == {WIDTH{1'b0}});
            divz_r      <= divz_s;
            cls_r       <= cls_s;
        end else if ((state_r == DIV) && div_done_s) begin
            out_valid_r <= 1'b1;
            out_lo_r    <= div_quo_s;
            out_hi_r    <= div_rem_s;
            carry_r     <= 1'b0;
            zero_r      <= (div_quo_s == {WIDTH{1'b0}});
            divz_r      <= 1'b0;
            cls_r       <= div_cls_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign ALU_OUT    = out_lo_r;
    assign ALU_OUT_HI = out_hi_r;
    assign CARRY_FLAG = carry_r;
    assign ZERO_FLAG  = zero_r;
    assign DIV_ZERO   = divz_r;
    assign ARITH_FLAG = cls_r.arith;
    assign LOGIC_FLAG = cls_r.logic_c;
    assign CMP_FLAG   = cls_r.cmp;
    assign SHIFT_FLAG = cls_r.shift;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=16) with hand-computed expectations.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT, ALU_OUT_HI;
    logic        out_valid;
    logic        ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
    logic        CARRY_FLAG, ZERO_FLAG, DIV_ZERO;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .ALU_OUT    (ALU_OUT),
        .ALU_OUT_HI (ALU_OUT_HI),
        .out_valid  (out_valid),
        .ARITH_FLAG (ARITH_FLAG),
        .LOGIC_FLAG (LOGIC_FLAG),
        .CMP_FLAG   (CMP_FLAG),
        .SHIFT_FLAG (SHIFT_FLAG),
        .CARRY_FLAG (CARRY_FLAG),
        .ZERO_FLAG  (ZERO_FLAG),
        .DIV_ZERO   (DIV_ZERO)
    );

    always #5 clk = ~clk;

    // flags packed as {ARITH, LOGIC, CMP, SHIFT}
    wire [3:0] cls = {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        ALU_FUN  = f;
        A        = a;
        B        = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int pulses;
        logic got;

        rst_n = 1'b0; in_valid = 1'b0; A = 16'h0000; B = 16'h0000; ALU_FUN = 4'b0000;
        tick(); tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", ALU_OUT, 16'h0000);
        chk("rst_hi", ALU_OUT_HI, 16'h0000);
        chk("rst_flags", {cls, CARRY_FLAG, ZERO_FLAG, DIV_ZERO}, 7'b0000000);
        rst_n = 1'b1;
        tick();

        // 1: ADD FFFF + 1
        drive(4'b0000, 16'hFFFF, 16'h0001);
        tick();
        in_valid = 1'b0;
        chk("add_not_yet", out_valid, 0);
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_out", ALU_OUT, 16'h0000);
        chk("add_cz", {CARRY_FLAG, ZERO_FLAG}, 2'b11);
        chk("add_cls", cls, 4'b1000);
        tick();
        chk("add_pulse_end", out_valid, 0);
        chk("add_hold", {ALU_OUT, CARRY_FLAG, ZERO_FLAG}, {16'h0000, 2'b11});

        // 2: MUL 1234 * 0100
        drive(4'b0010, 16'h1234, 16'h0100);
        tick(); in_valid = 1'b0; tick();
        chk("mul_valid", out_valid, 1);
        chk("mul_lo", ALU_OUT, 16'h3400);
        chk("mul_hi", ALU_OUT_HI, 16'h0012);
        chk("mul_carry", CARRY_FLAG, 0);

        // 3: DIV 100 / 7, with a competing request while busy
        drive(4'b0011, 16'd100, 16'd7);
        tick();
        in_valid = 1'b0;
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            if (k == 0) drive(4'b0000, 16'd1, 16'd1);
            if (k == 4) in_valid = 1'b0;
            tick();
            k++;
            if (out_valid) got = 1'b1;
            else chk("div_busy_ready", in_ready, 0);
        end
        chk("div_latency", k, 17);
        chk("div_quo", ALU_OUT, 16'd14);
        chk("div_rem", ALU_OUT_HI, 16'd2);
        chk("div_ready_back", in_ready, 1);
        chk("div_flags", {cls, CARRY_FLAG, ZERO_FLAG, DIV_ZERO}, 7'b1000000);
        tick();
        chk("div_no_extra", out_valid, 0);
        chk("div_hold", ALU_OUT, 16'd14);

        // 4: divide by zero
        drive(4'b0011, 16'h00AB, 16'h0000);
        tick(); in_valid = 1'b0; tick();
        chk("dz_valid", out_valid, 1);
        chk("dz_out", ALU_OUT, 16'hFFFF);
        chk("dz_hi", ALU_OUT_HI, 16'h00AB);
        chk("dz_flag", DIV_ZERO, 1);
        chk("dz_cls", cls, 4'b1000);
        chk("dz_ready", in_ready, 1);

        // 5: back-to-back GT, SHL, XNOR
        drive(4'b1011, 16'd5, 16'd3);
        tick();
        drive(4'b1110, 16'h8001, 16'h0000);
        tick();
        chk("gt_out", {out_valid, ALU_OUT}, {1'b1, 16'd2});
        chk("gt_cls", cls, 4'b0010);
        drive(4'b1001, 16'h0F0F, 16'h0F0F);
        tick();
        in_valid = 1'b0;
        chk("shl_out", {out_valid, ALU_OUT}, {1'b1, 16'h0002});
        chk("shl_flags", {cls, CARRY_FLAG}, 5'b00011);
        tick();
        chk("xnor_out", {out_valid, ALU_OUT}, {1'b1, 16'hFFFF});
        chk("xnor_flags", {cls, CARRY_FLAG, DIV_ZERO}, 6'b010000);

        // extra: SUB with borrow, EQ, reserved opcode
        drive(4'b0001, 16'd3, 16'd5);
        tick();
        drive(4'b1010, 16'h55AA, 16'h55AA);
        tick();
        chk("sub_out", {ALU_OUT, CARRY_FLAG}, {16'hFFFE, 1'b1});
        drive(4'b1111, 16'h1234, 16'h5678);
        tick();
        in_valid = 1'b0;
        chk("eq_out", {ALU_OUT, cls}, {16'd1, 4'b0010});
        tick();
        chk("rsvd_valid", out_valid, 1);
        chk("rsvd_out", {ALU_OUT, ALU_OUT_HI}, 32'h0000_0000);
        chk("rsvd_flags", {cls, CARRY_FLAG, ZERO_FLAG, DIV_ZERO}, 7'b0000010);

        // 6: reset in the middle of a division
        drive(4'b0011, 16'd1000, 16'd3);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_ready", in_ready, 1);
        chk("mrst_out", {ALU_OUT, ALU_OUT_HI}, 32'h0000_0000);
        chk("mrst_flags", {out_valid, cls, CARRY_FLAG, ZERO_FLAG, DIV_ZERO}, 8'h00);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("mrst_no_valid", pulses, 0);
        drive(4'b0000, 16'd2, 16'd3);
        tick(); in_valid = 1'b0; tick();
        chk("post_add", {out_valid, ALU_OUT, CARRY_FLAG, ZERO_FLAG}, {1'b1, 16'd5, 2'b00});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
